// File: rtl/minmax_scanner.sv
`default_nettype none
// ============================================================================
// Module   : minmax_scanner
// Brief    : Scans COUNT words of a 1-cycle-latency RAM from BASE and returns
//            the running max/min (signed or unsigned). Optional argmax/argmin
//            index outputs are built when MINMAX_ARGIDX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module minmax_scanner #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic          signed_mode,
  output logic          busy,
  output logic          done,
  output logic          result_valid,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] max_val,
  output logic [DW-1:0] min_val
`ifdef MINMAX_ARGIDX_EN
  ,
  output logic [AW-1:0] max_idx,
  output logic [AW-1:0] min_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_offset;
  logic [AW-1:0] r_count;
  logic          r_signed;
  logic          r_result_valid;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_min;

  logic [AW-1:0] w_offset_inc;
  logic          w_first;
  logic          w_last;
  logic          w_gt;
  logic          w_lt;
  logic          w_upd_max;
  logic          w_upd_min;

  assign w_offset_inc = r_offset + c_one;
  assign w_first      = (r_offset == '0);
  assign w_last       = (w_offset_inc == r_count);
  assign w_gt = r_signed ? ($signed(mem_rdata) > $signed(r_max)) : (mem_rdata > r_max);
  assign w_lt = r_signed ? ($signed(mem_rdata) < $signed(r_min)) : (mem_rdata < r_min);
  // Strict compares: ties keep the earliest element and its index.
  assign w_upd_max = (r_state == S_CHECK) && (w_first || w_gt);
  assign w_upd_min = (r_state == S_CHECK) && (w_first || w_lt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        mem_rd      = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr         <= '0;
      r_offset       <= '0;
      r_count        <= '0;
      r_signed       <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_result_valid <= 1'b0;
        if (count != '0) begin
          r_addr   <= base_addr;
          r_offset <= '0;
          r_count  <= count;
          r_signed <= signed_mode;
        end
      end else if (r_state == S_CHECK) begin
        if (w_last) begin
          r_result_valid <= 1'b1;
        end else begin
          r_addr   <= r_addr + c_one;
          r_offset <= w_offset_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max <= '0;
      r_min <= '0;
    end else begin
      if (w_upd_max) r_max <= mem_rdata;
      if (w_upd_min) r_min <= mem_rdata;
    end
  end

`ifdef MINMAX_ARGIDX_EN
  logic [AW-1:0] r_max_idx;
  logic [AW-1:0] r_min_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else begin
      if (w_upd_max) r_max_idx <= r_offset;
      if (w_upd_min) r_min_idx <= r_offset;
    end
  end

  assign max_idx = r_max_idx;
  assign min_idx = r_min_idx;
`endif

  assign mem_addr     = r_addr;
  assign result_valid = r_result_valid;
  assign max_val      = r_max;
  assign min_val      = r_min;

endmodule
`default_nettype wire

// File: tb/tb_minmax_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_minmax_scanner
// Brief    : Scoreboard bench for minmax_scanner; directed scans with
//            hand-computed results, checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minmax_scanner;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [7:0] mxi;
    logic [7:0] mni;
    logic       rv;
    int         done_cyc;
    int         nreads;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic          signed_mode;
  logic          busy;
  logic          done;
  logic          result_valid;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] max_val;
  logic [DW-1:0] min_val;
`ifdef MINMAX_ARGIDX_EN
  logic [AW-1:0] max_idx;
  logic [AW-1:0] min_idx;
`endif

  logic [DW-1:0] ram [0:255];
  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            done_seen = 0;
  int            rd_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  minmax_scanner #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .count        (count),
    .signed_mode  (signed_mode),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .max_val      (max_val),
    .min_val      (min_val)
`ifdef MINMAX_ARGIDX_EN
    ,
    .max_idx      (max_idx),
    .min_idx      (min_idx)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: read addresses and completed results against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_cnt = 0;
    end else begin
      if (mem_rd) begin
        rd_cnt++;
        if (addr_q.size() == 0) chk("unexpected_mem_rd", 1, 0);
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("max_val", max_val, mon_e.mx);
          chk("min_val", min_val, mon_e.mn);
          chk("result_valid", result_valid, mon_e.rv);
          chk("done_latency", cyc, mon_e.done_cyc);
          chk("read_count", rd_cnt, mon_e.nreads);
`ifdef MINMAX_ARGIDX_EN
          chk("max_idx", max_idx, mon_e.mxi);
          chk("min_idx", min_idx, mon_e.mni);
`endif
        end
        rd_cnt = 0;
        done_seen++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_max"}, max_val, 0);
    chk({tag, "_min"}, min_val, 0);
`ifdef MINMAX_ARGIDX_EN
    chk({tag, "_max_idx"}, max_idx, 0);
    chk({tag, "_min_idx"}, min_idx, 0);
`endif
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_scan(input logic [7:0] b, input logic [7:0] n, input logic sm,
                         input logic [7:0] emx, input logic [7:0] emn,
                         input logic [7:0] emxi, input logic [7:0] emni,
                         input logic erv, input int glitch);
    exp_t       e;
    logic [7:0] a;
    int         target;
    int         t;
    e.mx = emx; e.mn = emn; e.mxi = emxi; e.mni = emni; e.rv = erv;
    e.done_cyc = cyc + 2 * int'(n) + 1;
    e.nreads = int'(n);
    exp_q.push_back(e);
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      addr_q.push_back(a);
      a = a + 8'd1;
    end
    target = done_seen + 1;
    start = 1'b1; base_addr = b; count = n; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~b; count = 8'hFF; signed_mode = ~sm;
    chk("busy_after_start", busy, 1);
    chk("rv_cleared_on_start", result_valid, 0);
    if (glitch > 0) begin
      repeat (glitch) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_seen < target && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (done_seen < target) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'd5; ram[1] = 8'd9; ram[2] = 8'd2; ram[3] = 8'd7;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // unsigned basic scan
    do_scan(8'h00, 8'd4, 1'b0, 8'd9, 8'd2, 8'd1, 8'd2, 1'b1, 0);
    chk("rv_held_after_done", result_valid, 1);
    // signed, negative minimum
    ram[1] = 8'hF0;
    do_scan(8'h00, 8'd4, 1'b1, 8'd7, 8'hF0, 8'd3, 8'd1, 1'b1, 0);
    // same data unsigned: F0 becomes the maximum
    do_scan(8'h00, 8'd4, 1'b0, 8'hF0, 8'd2, 8'd1, 8'd2, 1'b1, 0);
    // empty scan: results kept, valid cleared, no reads
    do_scan(8'h40, 8'd0, 1'b0, 8'hF0, 8'd2, 8'd1, 8'd2, 1'b0, 0);
    // address wrap FE, FF, 00
    ram[8'hFE] = 8'd20; ram[8'hFF] = 8'd30;
    do_scan(8'hFE, 8'd3, 1'b0, 8'd30, 8'd5, 8'd1, 8'd2, 1'b1, 0);
    // all-equal words with a stray start mid-scan
    ram[8'h10] = 8'd4; ram[8'h11] = 8'd4; ram[8'h12] = 8'd4;
    do_scan(8'h10, 8'd3, 1'b0, 8'd4, 8'd4, 8'd0, 8'd0, 1'b1, 2);

    // abort during CHECK of word 2
    ram[8'h20] = 8'd1; ram[8'h21] = 8'd2; ram[8'h22] = 8'd3; ram[8'h23] = 8'd4;
    for (int i = 0; i < 4; i++) addr_q.push_back(8'h20 + 8'(i));
    start = 1'b1; base_addr = 8'h20; count = 8'd4; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = (mem_rd === 1'b1) ? 1 : 0;
    t = 0;
    while (k < 3 && t < 50) begin
      @(posedge clk); #1;
      if (mem_rd === 1'b1) k++;
      t++;
    end
    if (k < 3) chk("abort_read_timeout", 0, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    exp_q.delete();
    addr_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    do_scan(8'h20, 8'd4, 1'b0, 8'd4, 8'd1, 8'd3, 8'd0, 1'b1, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
